// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Instruction phase sequencer for a small microcoded CPU. A rising edge on
// start moves the sequencer from IDLE to RUN, where it steps the control-unit
// phase 0..5 once per clock. Each 5->0 wrap retires one instruction; with
// step_mode set the sequencer drops back to IDLE after that wrap. At phase 4
// the control unit can request an OUT or IN transfer, which parks the
// sequencer in WAIT_IO until the matching acknowledge arrives. A halt request
// at phases 1..5 parks it in HALT until reset.
//
// Optional feature (compile-time macro PHASE_SEQ_INSTR_COUNT_EN):
//   defined   -> instr_count counts retired instructions, saturating at FFFF
//   undefined -> instr_count is tied to zero (port kept)
//
// Ports
//   clk          in   1   system clock, all state changes on the rising edge
//   rst          in   1   synchronous reset, active low
//   start        in   1   run button (synchronous); only its rising edge acts
//   step_mode    in   1   1 = return to IDLE after each instruction
//   hlt          in   1   halt request from the control unit
//   out_s        in   1   OUT request from the control unit (phase 4)
//   in_s         in   1   IN request from the control unit (phase 4)
//   out_src      in  16   value to emit on OUT
//   in_src       in  16   switch value offered for IN
//   out_ack      in   1   display consumed out_data
//   in_ack       in   1   in_src is valid
//   phase        out  3   current phase 0..5
//   running      out  1   sequencer in RUN or WAIT_IO
//   halted       out  1   sequencer in HALT
//   out_req      out  1   OUT handshake request
//   out_data     out 16   value latched for OUT
//   in_req       out  1   IN handshake request
//   in_data      out 16   switch value latched on IN acknowledge
//   instr_count  out 16   retired-instruction count
// -----------------------------------------------------------------------------
module phase_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        step_mode,
   input  logic        hlt,
   input  logic        out_s,
   input  logic        in_s,
   input  logic [15:0] out_src,
   input  logic [15:0] in_src,
   input  logic        out_ack,
   input  logic        in_ack,
   output logic [2:0]  phase,
   output logic        running,
   output logic        halted,
   output logic        out_req,
   output logic [15:0] out_data,
   output logic        in_req,
   output logic [15:0] in_data,
   output logic [15:0] instr_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_WAIT_IO = 2'd2,
      ST_HALT    = 2'd3
   } state_t;

   state_t      state_r;
   logic [2:0]  phase_r;
   logic        running_r;
   logic        halted_r;
   logic        out_req_r;
   logic        in_req_r;
   logic [15:0] out_data_r;
   logic [15:0] in_data_r;
   logic        start_d_r;

   logic        start_edge_s;
   logic        retire_s;

   assign start_edge_s = start & ~start_d_r;

   // A wrap from phase 5 retires unless a halt request wins the same cycle.
   assign retire_s = (state_r == ST_RUN) && (phase_r >= 3'd5) && !hlt;

   // Sequencer FSM with registered status and handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         phase_r    <= 3'd0;
         running_r  <= 1'b0;
         halted_r   <= 1'b0;
         out_req_r  <= 1'b0;
         in_req_r   <= 1'b0;
         out_data_r <= 16'd0;
         in_data_r  <= 16'd0;
         start_d_r  <= 1'b0;
      end else begin
         start_d_r <= start;
         case (state_r)
            ST_IDLE: begin
               phase_r <= 3'd0;
               if (start_edge_s) begin
                  state_r   <= ST_RUN;
                  running_r <= 1'b1;
               end
            end

            ST_RUN: begin
               // Priority: halt, then OUT, then IN, then normal stepping.
               if (hlt && (phase_r != 3'd0)) begin
                  state_r   <= ST_HALT;
                  phase_r   <= 3'd0;
                  running_r <= 1'b0;
                  halted_r  <= 1'b1;
               end else if ((phase_r == 3'd4) && out_s) begin
                  out_data_r <= out_src;
                  out_req_r  <= 1'b1;
                  state_r    <= ST_WAIT_IO;
               end else if ((phase_r == 3'd4) && in_s) begin
                  in_req_r <= 1'b1;
                  state_r  <= ST_WAIT_IO;
               end else if (phase_r >= 3'd5) begin
                  phase_r <= 3'd0;
                  if (step_mode) begin
                     state_r   <= ST_IDLE;
                     running_r <= 1'b0;
                  end
               end else begin
                  phase_r <= phase_r + 3'd1;
               end
            end

            ST_WAIT_IO: begin
               // Only the ack matching the outstanding request is honoured.
               if (out_req_r && out_ack) begin
                  out_req_r <= 1'b0;
                  state_r   <= ST_RUN;
                  phase_r   <= 3'd5;
               end else if (in_req_r && in_ack) begin
                  in_data_r <= in_src;
                  in_req_r  <= 1'b0;
                  state_r   <= ST_RUN;
                  phase_r   <= 3'd5;
               end
            end

            ST_HALT: begin
               phase_r <= 3'd0;
            end

            default: begin
               state_r   <= ST_IDLE;
               phase_r   <= 3'd0;
               running_r <= 1'b0;
               halted_r  <= 1'b0;
               out_req_r <= 1'b0;
               in_req_r  <= 1'b0;
            end
         endcase
      end
   end

`ifdef PHASE_SEQ_INSTR_COUNT_EN
   logic [15:0] instr_count_r;

   // Retired-instruction counter, saturating so it never wraps to zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         instr_count_r <= 16'd0;
      end else if (retire_s && (instr_count_r != 16'hFFFF)) begin
         instr_count_r <= instr_count_r + 16'd1;
      end
   end

   assign instr_count = instr_count_r;
`else
   logic unused_retire_s;
   assign unused_retire_s = retire_s;
   assign instr_count     = 16'd0;
`endif

   assign phase    = phase_r;
   assign running  = running_r;
   assign halted   = halted_r;
   assign out_req  = out_req_r;
   assign out_data = out_data_r;
   assign in_req   = in_req_r;
   assign in_data  = in_data_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//
// Self-checking bench for phase_sequencer. The stimulus process drives inputs
// on the falling edge, advances a behavioural model of the sequencer by one
// clock and queues the outputs that model expects after the next rising edge.
// A monitor pops one entry after every rising edge and compares it with the
// DUT outputs. Directed scenarios come first, then a randomized run.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        step_mode = 1'b0;
   logic        hlt = 1'b0;
   logic        out_s = 1'b0;
   logic        in_s = 1'b0;
   logic [15:0] out_src = 16'd0;
   logic [15:0] in_src = 16'd0;
   logic        out_ack = 1'b0;
   logic        in_ack = 1'b0;
   logic [2:0]  phase;
   logic        running;
   logic        halted;
   logic        out_req;
   logic [15:0] out_data;
   logic        in_req;
   logic [15:0] in_data;
   logic [15:0] instr_count;

   int n_checks = 0;
   int n_fail   = 0;
   bit done     = 1'b0;

`ifdef PHASE_SEQ_INSTR_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   phase_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .step_mode   (step_mode),
      .hlt         (hlt),
      .out_s       (out_s),
      .in_s        (in_s),
      .out_src     (out_src),
      .in_src      (in_src),
      .out_ack     (out_ack),
      .in_ack      (in_ack),
      .phase       (phase),
      .running     (running),
      .halted      (halted),
      .out_req     (out_req),
      .out_data    (out_data),
      .in_req      (in_req),
      .in_data     (in_data),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          phase;
      bit          running;
      bit          halted;
      bit          out_req;
      bit          in_req;
      logic [15:0] out_data;
      logic [15:0] in_data;
      logic [15:0] count;
   } exp_t;

   exp_t sb_q[$];

   // Behavioural model: "active" covers RUN and WAIT_IO, "waiting" marks a
   // pending I/O transfer, "halted" is sticky until reset.
   bit          m_active, m_waiting, m_halted, m_prev_start;
   bit          m_oreq, m_ireq;
   int          m_phase;
   int          m_count;
   logic [15:0] m_odata, m_idata;

   task automatic model_step();
      exp_t e;
      bit   rise;
      if (!rst) begin
         m_active = 0; m_waiting = 0; m_halted = 0; m_prev_start = 0;
         m_oreq = 0; m_ireq = 0; m_phase = 0; m_count = 0;
         m_odata = 16'd0; m_idata = 16'd0;
      end else begin
         rise = start && !m_prev_start;
         m_prev_start = start;
         if (m_halted) begin
            m_phase = 0;
         end else if (!m_active) begin
            m_phase = 0;
            if (rise) m_active = 1;
         end else if (m_waiting) begin
            if (m_oreq && out_ack) begin
               m_oreq = 0; m_waiting = 0; m_phase = 5;
            end else if (m_ireq && in_ack) begin
               m_idata = in_src; m_ireq = 0; m_waiting = 0; m_phase = 5;
            end
         end else if (hlt && m_phase >= 1) begin
            m_halted = 1; m_active = 0; m_phase = 0;
         end else if (m_phase == 4 && out_s) begin
            m_odata = out_src; m_oreq = 1; m_waiting = 1;
         end else if (m_phase == 4 && in_s) begin
            m_ireq = 1; m_waiting = 1;
         end else if (m_phase == 5) begin
            m_phase = 0;
            if (CNT_EN && m_count < 65535) m_count = m_count + 1;
            if (step_mode) m_active = 0;
         end else begin
            m_phase = m_phase + 1;
         end
      end
      e.phase    = m_phase;
      e.running  = m_active;
      e.halted   = m_halted;
      e.out_req  = m_oreq;
      e.in_req   = m_ireq;
      e.out_data = m_odata;
      e.in_data  = m_idata;
      e.count    = 16'(m_count);
      sb_q.push_back(e);
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: one expected entry per rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!done) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got 0 entries expected 1 at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            chk("phase",       32'(phase),       32'(e.phase));
            chk("running",     32'(running),     32'(e.running));
            chk("halted",      32'(halted),      32'(e.halted));
            chk("out_req",     32'(out_req),     32'(e.out_req));
            chk("in_req",      32'(in_req),      32'(e.in_req));
            chk("out_data",    32'(out_data),    32'(e.out_data));
            chk("in_data",     32'(in_data),     32'(e.in_data));
            chk("instr_count", 32'(instr_count), 32'(e.count));
            chk("req_excl",    32'(out_req & in_req), 32'd0);
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1; tick();
      start = 1'b0; tick();
   endtask

   // Tick until the model is running (not waiting) at phase p, bounded.
   task automatic wait_phase(input int p);
      for (int i = 0; i < 40; i++) begin
         if (m_active && !m_waiting && m_phase == p) break;
         tick();
      end
      if (!(m_active && !m_waiting && m_phase == p)) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_phase: got phase %0d expected %0d (timeout)", m_phase, p);
      end
   endtask

   initial begin
      // Reset
      rst = 1'b0; tick(); tick();
      rst = 1'b1; tick();

      // Free run: two full passes
      pulse_start();
      repeat (12) tick();

      // Single-step: finish current pass, then one pass per start pulse
      step_mode = 1'b1;
      repeat (10) tick();
      pulse_start();
      repeat (8) tick();
      step_mode = 1'b0;

      // OUT with ack delayed 3 clocks
      pulse_start();
      wait_phase(4);
      out_s = 1'b1; out_src = 16'hBEEF; tick();
      out_s = 1'b0; out_src = 16'h0000;
      repeat (2) tick();
      in_ack = 1'b1; tick();          // wrong ack must be ignored
      in_ack = 1'b0;
      out_ack = 1'b1; tick();
      out_ack = 1'b0; tick(); tick();

      // IN with ack and out_s/in_s together (out_s wins)
      wait_phase(4);
      in_s = 1'b1; in_ack = 1'b1; in_src = 16'h1234; tick();
      in_s = 1'b0; tick();
      in_ack = 1'b0; in_src = 16'h5555; tick(); tick();
      wait_phase(4);
      out_s = 1'b1; in_s = 1'b1; out_src = 16'hA5A5; tick();
      out_s = 1'b0; in_s = 1'b0; out_ack = 1'b1; tick();
      out_ack = 1'b0; tick();

      // Halt at phase 2, start ignored, reset recovers
      wait_phase(2);
      hlt = 1'b1; tick();
      hlt = 1'b0; tick();
      pulse_start();
      tick();
      rst = 1'b0; tick();
      rst = 1'b1; tick();

      // Reset mid OUT handshake
      pulse_start();
      wait_phase(4);
      out_s = 1'b1; out_src = 16'h0F0F; tick();
      out_s = 1'b0; tick();
      rst = 1'b0; tick();
      rst = 1'b1; tick(); tick();

`ifdef PHASE_SEQ_INSTR_COUNT_EN
      // Saturation: preset the counter, then retire once more
      force dut.instr_count_r = 16'hFFFF;
      #1;
      release dut.instr_count_r;
      m_count = 65535;
      pulse_start();
      repeat (8) tick();
      rst = 1'b0; tick();
      rst = 1'b1; tick();
`endif

      // Randomized run
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 199) != 0);
         start     = ($urandom_range(0, 7) == 0);
         hlt       = ($urandom_range(0, 59) == 0);
         out_s     = ($urandom_range(0, 2) == 0);
         in_s      = ($urandom_range(0, 2) == 0);
         out_ack   = ($urandom_range(0, 2) == 0);
         in_ack    = ($urandom_range(0, 2) == 0);
         out_src   = 16'($urandom());
         in_src    = 16'($urandom());
         if ($urandom_range(0, 49) == 0) step_mode = ~step_mode;
         tick();
      end

      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
